// File: rtl/clk_pkg.sv
// Shared definitions for the slow-clock divider and its receive-side monitor.
package clk_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2,
        LOST    = 2'd3
    } mon_state_t;

    localparam int DEF_CNT_W   = 26;
    localparam int DEF_TIMEOUT = 50_000_000;

endpackage

// File: rtl/sync_edge_det.sv
// Three-flop synchroniser with rising-edge detect for an asynchronous level input.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic       s1_reg;
    logic       s2_reg;
    logic       s3_reg;
    logic [2:0] warm_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_reg   <= 1'b0;
            s2_reg   <= 1'b0;
            s3_reg   <= 1'b0;
            warm_reg <= '0;
        end else begin
            s1_reg   <= din;
            s2_reg   <= s1_reg;
            s3_reg   <= s2_reg;
            warm_reg <= {warm_reg[1:0], 1'b1};
        end
    end

    // Until s3 holds a real post-reset sample, an input already high at
    // reset release would look like an edge; warm_reg masks that window.
    assign rise = s2_reg & ~s3_reg & warm_reg[2];

endmodule

// File: rtl/slow_clk_monitor.sv
// Turns slow_clk into a one-cycle tick enable and tracks its period, lock and stall status.
module slow_clk_monitor
    import clk_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int TOL        = 2,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             slow_clk,
    output logic             tick,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             stalled,
    output logic [15:0]      edge_count
);

    localparam int               MATCH_W   = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]   TOL_C     = (CNT_W + 1)'(TOL);
    localparam logic [MATCH_W-1:0] LOCK_C  = MATCH_W'(LOCK_COUNT);

    mon_state_t         state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [MATCH_W-1:0] match_reg;
    logic [CNT_W-1:0]   period_reg;
    logic               period_valid_reg;
    logic               locked_reg;
    logic               stalled_reg;
    logic               tick_reg;
    logic [15:0]        edge_count_reg;

    logic               rise;
    logic [CNT_W:0]     cnt_ext;
    logic [CNT_W:0]     period_ext;
    logic [CNT_W:0]     diff;
    logic               in_tol;
    logic [CNT_W-1:0]   cnt_next;
    logic [MATCH_W-1:0] match_next;
    logic               timeout_hit;

    sync_edge_det u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (slow_clk),
        .rise  (rise)
    );

    // One extra bit keeps the subtraction free of wrap-around.
    assign cnt_ext     = {1'b0, cnt_reg};
    assign period_ext  = {1'b0, period_reg};
    assign diff        = (cnt_ext >= period_ext) ? (cnt_ext - period_ext) : (period_ext - cnt_ext);
    assign in_tol      = (diff <= TOL_C);
    assign cnt_next    = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
    assign match_next  = match_reg + 1'b1;
    assign timeout_hit = (cnt_reg >= TIMEOUT_C);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            match_reg        <= '0;
            period_reg       <= '0;
            period_valid_reg <= 1'b0;
            locked_reg       <= 1'b0;
            stalled_reg      <= 1'b0;
            tick_reg         <= 1'b0;
            edge_count_reg   <= '0;
        end else begin
            tick_reg <= rise;
            if (rise) begin
                edge_count_reg <= edge_count_reg + 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (rise) begin
                        cnt_reg   <= CNT_ONE;
                        state_reg <= MEASURE;
                    end else begin
                        cnt_reg <= '0;
                    end
                end

                MEASURE: begin
                    if (rise) begin
                        cnt_reg    <= CNT_ONE;
                        period_reg <= cnt_reg;
                        if (!period_valid_reg) begin
                            period_valid_reg <= 1'b1;
                            match_reg        <= '0;
                        end else if (in_tol) begin
                            match_reg <= match_next;
                            if (match_next == LOCK_C) begin
                                state_reg  <= LOCKED;
                                locked_reg <= 1'b1;
                            end
                        end else begin
                            match_reg <= '0;
                        end
                    end else if (timeout_hit) begin
                        cnt_reg          <= cnt_next;
                        state_reg        <= LOST;
                        stalled_reg      <= 1'b1;
                        locked_reg       <= 1'b0;
                        period_valid_reg <= 1'b0;
                        match_reg        <= '0;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end

                LOCKED: begin
                    if (rise) begin
                        cnt_reg    <= CNT_ONE;
                        period_reg <= cnt_reg;
                        if (!in_tol) begin
                            match_reg  <= '0;
                            locked_reg <= 1'b0;
                            state_reg  <= MEASURE;
                        end
                    end else if (timeout_hit) begin
                        cnt_reg          <= cnt_next;
                        state_reg        <= LOST;
                        stalled_reg      <= 1'b1;
                        locked_reg       <= 1'b0;
                        period_valid_reg <= 1'b0;
                        match_reg        <= '0;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end

                LOST: begin
                    if (rise) begin
                        cnt_reg     <= CNT_ONE;
                        stalled_reg <= 1'b0;
                        state_reg   <= MEASURE;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign tick         = tick_reg;
    assign period       = period_reg;
    assign period_valid = period_valid_reg;
    assign locked       = locked_reg;
    assign stalled      = stalled_reg;
    assign edge_count   = edge_count_reg;

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Bench for slow_clk_monitor: vector table for the lock sequence, tick-timing scoreboard, corner-case sequences.
module tb_slow_clk_monitor;

    localparam int CNT_W      = 16;
    localparam int TOL        = 1;
    localparam int LOCK_COUNT = 3;
    localparam int TIMEOUT    = 20;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             slow_clk = 1'b0;
    logic             tick;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             stalled;
    logic [15:0]      edge_count;

    slow_clk_monitor #(
        .CNT_W      (CNT_W),
        .TOL        (TOL),
        .LOCK_COUNT (LOCK_COUNT),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .slow_clk     (slow_clk),
        .tick         (tick),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .stalled      (stalled),
        .edge_count   (edge_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   gap;
        int   per;
        logic valid;
        logic lockd;
        logic stall;
        int   edges;
    } vec_t;

    vec_t vecs [17];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   exp_q [$];
    int   last_tick_cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_outputs(input string tag, input int per, input int valid,
                                 input int lockd, input int stall, input int edges);
        check({tag, ".period"},       int'(period),       per);
        check({tag, ".period_valid"}, int'(period_valid), valid);
        check({tag, ".locked"},       int'(locked),       lockd);
        check({tag, ".stalled"},      int'(stalled),      stall);
        check({tag, ".edge_count"},   int'(edge_count),   edges);
    endtask

    // Raise slow_clk at a negedge; the tick must appear three sampling edges later.
    task automatic push_rise();
        slow_clk = 1'b1;
        last_tick_cyc = cyc + 3;
        exp_q.push_back(cyc + 3);
    endtask

    task automatic pulse_start();
        push_rise();
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_end(input int p);
        for (int i = 3; i < p; i++) begin
            if (i >= p / 2) slow_clk = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        vecs[0]  = '{8,  0,  1'b0, 1'b0, 1'b0, 1};
        vecs[1]  = '{8,  8,  1'b1, 1'b0, 1'b0, 2};
        vecs[2]  = '{8,  8,  1'b1, 1'b0, 1'b0, 3};
        vecs[3]  = '{8,  8,  1'b1, 1'b0, 1'b0, 4};
        vecs[4]  = '{9,  8,  1'b1, 1'b1, 1'b0, 5};
        vecs[5]  = '{12, 9,  1'b1, 1'b1, 1'b0, 6};
        vecs[6]  = '{8,  12, 1'b1, 1'b0, 1'b0, 7};
        vecs[7]  = '{8,  8,  1'b1, 1'b0, 1'b0, 8};
        vecs[8]  = '{8,  8,  1'b1, 1'b0, 1'b0, 9};
        vecs[9]  = '{8,  8,  1'b1, 1'b0, 1'b0, 10};
        vecs[10] = '{20, 8,  1'b1, 1'b1, 1'b0, 11};
        vecs[11] = '{20, 20, 1'b1, 1'b0, 1'b0, 12};
        vecs[12] = '{8,  20, 1'b1, 1'b0, 1'b0, 13};
        vecs[13] = '{8,  8,  1'b1, 1'b0, 1'b0, 14};
        vecs[14] = '{8,  8,  1'b1, 1'b0, 1'b0, 15};
        vecs[15] = '{8,  8,  1'b1, 1'b0, 1'b0, 16};
        vecs[16] = '{0,  8,  1'b1, 1'b1, 1'b0, 17};

        fork
            // Tick scoreboard: every tick must match the oldest pending expectation.
            forever begin
                @(negedge clk);
                while (exp_q.size() > 0 && exp_q[0] < cyc) begin
                    check("tick_missing", 0, exp_q.pop_front());
                end
                if (rst_n && tick) begin
                    if (exp_q.size() == 0) check("tick_unexpected", cyc, -1);
                    else                   check("tick_cycle", cyc, exp_q.pop_front());
                end
            end
            begin
                #5_000_000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset held while slow_clk toggles, then released with slow_clk high.
        rst_n = 1'b0;
        repeat (6) begin
            @(negedge clk);
            slow_clk = ~slow_clk;
        end
        @(negedge clk);
        check("reset.tick", int'(tick), 0);
        check_outputs("reset", 0, 0, 0, 0, 0);
        slow_clk = 1'b1;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check_outputs("release_high", 0, 0, 0, 0, 0);
        $display("txn reset: edge_count=%0d period_valid=%0d", edge_count, period_valid);
        slow_clk = 1'b0;
        repeat (3) @(negedge clk);

        // Lock, tolerance, lock loss and rise-at-timeout vectors.
        for (int i = 0; i < 17; i++) begin
            pulse_start();
            check_outputs($sformatf("vec%0d", i), vecs[i].per, int'(vecs[i].valid),
                          int'(vecs[i].lockd), int'(vecs[i].stall), vecs[i].edges);
            $display("txn vec%0d: period=%0d valid=%0d locked=%0d stalled=%0d edges=%0d",
                     i, period, period_valid, locked, stalled, edge_count);
            if (vecs[i].gap > 0) pulse_end(vecs[i].gap);
        end

        // Stall: slow_clk held low after locking at 8.
        begin
            int stall_cyc;
            stall_cyc = -1;
            slow_clk = 1'b0;
            for (int k = 0; k < 40 && stall_cyc < 0; k++) begin
                @(negedge clk);
                if (stalled) stall_cyc = cyc;
            end
            check("stall_cycle", stall_cyc, last_tick_cyc + TIMEOUT);
            check_outputs("stall", 8, 0, 0, 1, 17);
            $display("txn stall: at cycle %0d period=%0d", stall_cyc, period);
            repeat (10) @(negedge clk);
            check("stall_hold.stalled", int'(stalled), 1);
        end

        // Recovery from LOST: first rise only re-enters MEASURE, second captures.
        pulse_start();
        check_outputs("recover1", 8, 0, 0, 0, 18);
        $display("txn recover1: stalled=%0d period_valid=%0d", stalled, period_valid);
        pulse_end(8);
        pulse_start();
        check_outputs("recover2", 8, 1, 0, 0, 19);
        $display("txn recover2: period=%0d period_valid=%0d", period, period_valid);
        pulse_end(6);

        // Reset mid-measurement discards everything.
        rst_n = 1'b0;
        repeat (4) begin
            @(negedge clk);
            slow_clk = ~slow_clk;
        end
        @(negedge clk);
        check_outputs("mid_reset", 0, 0, 0, 0, 0);
        slow_clk = 1'b1;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("mid_release.edge_count", int'(edge_count), 0);
        slow_clk = 1'b0;
        repeat (2) @(negedge clk);
        pulse_start();
        check_outputs("first_edge", 0, 0, 0, 0, 1);
        $display("txn first_edge: edge_count=%0d period_valid=%0d", edge_count, period_valid);
        pulse_end(4);

        // edge_count wrap: 65535 rises reach 0xFFFF, one more wraps to 0.
        rst_n = 1'b0;
        slow_clk = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 65535; i++) begin
            push_rise();
            @(negedge clk);
            slow_clk = 1'b0;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("wrap.edge_count_ffff", int'(edge_count), 65535);
        push_rise();
        @(negedge clk);
        slow_clk = 1'b0;
        repeat (4) @(negedge clk);
        check("wrap.edge_count_zero", int'(edge_count), 0);
        $display("txn wrap: edge_count=%0d", edge_count);

        repeat (5) @(negedge clk);
        check("tick_pending", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/slow_clk_monitor.md
Name: slow_clk_monitor

Overview:
- Receive-side companion to slow_clock: consumes the divided clock `slow_clk` as a data signal in the `clk` domain.
- Produces a single-cycle `tick` enable per slow_clk rising edge, so game logic runs on `clk` with clock enables instead of a derived clock.
- Measures the slow_clk period in clk cycles and reports lock and stall status for the divider chain.

Parameters:
- CNT_W, 26, width of the period counter and the `period` output.
- TOL, 2, maximum |new period − previous period| (in clk cycles) still counted as a match.
- LOCK_COUNT, 4, consecutive matching periods required to assert `locked`.
- TIMEOUT, 50000000, clk cycles without a rising edge before `stalled`. Must be ≤ 2^CNT_W−1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous reset, active-low.
- slow_clk  in  1  divided clock from slow_clock; asynchronous to this block's sampling.
- tick  out  1  one-cycle pulse per detected slow_clk rising edge.
- period  out  CNT_W  last measured rise-to-rise interval, in clk cycles.
- period_valid  out  1  `period` holds at least one complete measurement.
- locked  out  1  period stable for LOCK_COUNT consecutive matches.
- stalled  out  1  no rising edge for TIMEOUT cycles.
- edge_count  out  16  number of rising edges seen; wraps 0xFFFF→0.

Behaviour:
- Reset (rst_n low at a clk edge) clears everything:
  - Outputs: tick=0, period=0, period_valid=0, locked=0, stalled=0, edge_count=0.
  - Internals: sync regs s1/s2/s3=0, cnt=0, match=0, state=IDLE.
  - Reset mid-operation discards the measurement in progress. A slow_clk already high when reset releases is not an edge.
- Synchroniser:
  - s1<=slow_clk, s2<=s1, s3<=s2. rise = s2 & ~s3, combinational.
  - tick is a register: tick<=rise.
  - Latency: slow_clk first sampled high at edge N → tick high for exactly one cycle after edge N+2.
- cnt:
  - Increments every cycle, saturating at 2^CNT_W−1.
  - On rise: cnt<=1. The captured interval is the cnt value before the reset to 1.
- edge_count increments on every rise, in every state.
- State IDLE:
  - No edge seen yet. cnt held at 0.
  - On rise → MEASURE, cnt<=1.
  - No timeout applies in IDLE.
- State MEASURE, on rise:
  - If period_valid=0: period<=cnt, period_valid<=1, match<=0.
  - Else if |cnt−period| ≤ TOL: match<=match+1.
  - Else: match<=0.
  - In both period_valid=1 cases, period<=cnt.
  - When match reaches LOCK_COUNT → LOCKED, locked<=1.
- State LOCKED:
  - On rise with |cnt−period| ≤ TOL: period<=cnt, stay in LOCKED.
  - On rise with |cnt−period| > TOL: period<=cnt, match<=0, locked<=0, → MEASURE.
- Timeout (MEASURE or LOCKED):
  - If cnt reaches TIMEOUT with no rise in that cycle → LOST.
  - On entry to LOST: stalled<=1, locked<=0, period_valid<=0, match<=0. period keeps its last value.
- State LOST:
  - On rise → MEASURE, stalled<=0, cnt<=1.
- Simultaneous rise and timeout in the same cycle: rise wins, no stall.
- Difference arithmetic: compare in CNT_W+1 bits, unsigned absolute difference.
- Saturated cnt is treated as a normal value in the compare.
- Outputs are registered; none are combinational from slow_clk.

Decomposition:
- Shared package `clk_pkg`:
  - State enum constants IDLE=2'd0, MEASURE=2'd1, LOCKED=2'd2, LOST=2'd3.
  - Default CNT_W/TIMEOUT constants, shared with slow_clock.
- One natural sub-module: `sync_edge_det` (3-flop synchroniser plus rise detect, outputs `rise`). Reused for button inputs elsewhere.

Test Plan:
- Reset: hold rst_n=0 with slow_clk toggling → all outputs 0. Release with slow_clk=1 steady → no tick, edge_count=0.
- Latency and pulse width: single slow_clk 0→1 sampled at edge N → tick=1 only in the cycle after edge N+2. edge_count=1, state MEASURE, period_valid=0.
- Lock (TOL=1, LOCK_COUNT=3): slow_clk period 8 clk.
  - After the 2nd rise: period=8, period_valid=1.
  - After the 5th rise: locked=1.
  - Tick spacing is exactly 8 cycles.
- Tolerance and lock loss:
  - Locked at 8, then one period of 9 → locked stays 1, period=9.
  - Then a period of 12 → locked=0, match=0, period=12, state MEASURE.
- Stall (TIMEOUT=20): locked at 8, then slow_clk held low.
  - cnt hits 20 → stalled=1, locked=0, period_valid=0, period=8 retained.
  - Next rise → stalled=0, state MEASURE.
- Boundary cases:
  - A rise coinciding with cnt==TIMEOUT → no stall.
  - 65536 rises → edge_count wraps to 0.
